// File: rtl/regfile_pkg.sv
// Shared types and helpers for the 2-read/1-write register bank.
package regfile_pkg;

   typedef enum logic {INIT, READY} state_e;

   // Widest entry supported by byte_merge; callers zero-extend into it.
   localparam int MAX_DATA_W = 256;
   localparam int MAX_BE_W   = MAX_DATA_W / 8;

   function automatic logic [MAX_DATA_W-1:0] byte_merge(
      input logic [MAX_DATA_W-1:0] old_d,
      input logic [MAX_DATA_W-1:0] new_d,
      input logic [MAX_BE_W-1:0]   be
   );
      logic [MAX_DATA_W-1:0] r;
      r = old_d;
      for (int i = 0; i < MAX_BE_W; i++)
         if (be[i]) r[8*i +: 8] = new_d[8*i +: 8];
      return r;
   endfunction

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback-facing bus of the register bank.
interface regfile_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic                  we;
   logic [ADDR_W-1:0]     waddr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wbe;
   logic [ADDR_W-1:0]     raddr_a;
   logic [ADDR_W-1:0]     raddr_b;
   logic [DATA_W-1:0]     rdata_a;
   logic [DATA_W-1:0]     rdata_b;
   logic                  init_done;

   modport master (
      output we, waddr, wdata, wbe, raddr_a, raddr_b,
      input  rdata_a, rdata_b, init_done
   );

   modport slave (
      input  we, waddr, wdata, wbe, raddr_a, raddr_b,
      output rdata_a, rdata_b, init_done
   );
endinterface

// File: rtl/regfile_init_seq.sv
// Post-reset clear sequencer: walks every entry once, then reports ready.
module regfile_init_seq
   import regfile_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   output logic              o_clr_we,
   output logic [ADDR_W-1:0] o_clr_addr,
   output logic              o_init_done
);

   state_e            r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic              r_init_done;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= INIT;
         r_ptr       <= '0;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            INIT: begin
               r_ptr <= r_ptr + ADDR_W'(1);
               if (&r_ptr) begin
                  r_state     <= READY;
                  r_init_done <= 1'b1;
               end
            end
            default: r_init_done <= 1'b1;
         endcase
      end
   end

   assign o_clr_we    = ~r_init_done;
   assign o_clr_addr  = r_ptr;
   assign o_init_done = r_init_done;

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register bank with byte enables, zero entry, bypass
// and optional registered reads.
module regfile_2r1w
   import regfile_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int ZERO_REG  = 1,
   parameter int BYPASS    = 1,
   parameter int SYNC_READ = 0
) (
   input  logic     i_clk,
   input  logic     i_rst_n,
   regfile_if.slave bus
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int BE_W  = DATA_W / 8;

   if ((DATA_W % 8) != 0 || DATA_W > MAX_DATA_W) begin : g_bad_width
      $error("regfile_2r1w: DATA_W must be a multiple of 8 and <= MAX_DATA_W");
   end

   logic [DEPTH-1:0][DATA_W-1:0] r_mem;
   logic                         w_clr_we;
   logic [ADDR_W-1:0]            w_clr_addr;
   logic                         w_init_done;
   logic                         w_wr_en;
   logic [DATA_W-1:0]            w_wr_data;
   logic [1:0][ADDR_W-1:0]       w_raddr;
   logic [1:0][DATA_W-1:0]       w_rd;

   regfile_init_seq #(.ADDR_W(ADDR_W)) u_init (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .o_clr_we    (w_clr_we),
      .o_clr_addr  (w_clr_addr),
      .o_init_done (w_init_done)
   );

   assign w_wr_en   = w_init_done & bus.we & ~((ZERO_REG != 0) && (bus.waddr == '0));
   assign w_wr_data = DATA_W'(byte_merge(MAX_DATA_W'(r_mem[bus.waddr]),
                                         MAX_DATA_W'(bus.wdata),
                                         MAX_BE_W'(bus.wbe)));

   // Reset leaves the array alone; the clear sequencer owns zeroing it.
   always_ff @(posedge i_clk) begin
      if (i_rst_n) begin
         if (w_clr_we)     r_mem[w_clr_addr] <= '0;
         else if (w_wr_en) r_mem[bus.waddr]  <= w_wr_data;
      end
   end

   assign w_raddr = {bus.raddr_b, bus.raddr_a};

   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic w_hit;
      assign w_hit = (BYPASS != 0) && bus.we && (bus.waddr == w_raddr[p]);

      always_comb begin
         w_rd[p] = r_mem[w_raddr[p]];
         if (!w_init_done)
            w_rd[p] = '0;
         else if ((ZERO_REG != 0) && (w_raddr[p] == '0))
            w_rd[p] = '0;
         else if (w_hit)
            w_rd[p] = DATA_W'(byte_merge(MAX_DATA_W'(r_mem[w_raddr[p]]),
                                         MAX_DATA_W'(bus.wdata),
                                         MAX_BE_W'(bus.wbe)));
      end
   end

   if (SYNC_READ != 0) begin : g_sync
      logic [1:0][DATA_W-1:0] r_rdata;
      always_ff @(posedge i_clk) begin
         if (!i_rst_n) r_rdata <= '0;
         else          r_rdata <= w_rd;
      end
      assign bus.rdata_a = r_rdata[0];
      assign bus.rdata_b = r_rdata[1];
   end else begin : g_comb
      assign bus.rdata_a = w_rd[0];
      assign bus.rdata_b = w_rd[1];
   end

   assign bus.init_done = w_init_done;

   logic [BE_W-1:0] w_unused_be;
   assign w_unused_be = bus.wbe;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench: default config, no-zero/no-bypass config, registered-read config.
module tb_regfile_2r1w;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we;
   logic [4:0]  waddr, ra, rb;
   logic [31:0] wdata;
   logic [3:0]  wbe;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_edges;

   always #5 clk = ~clk;

   regfile_if #(.DATA_W(32), .ADDR_W(5)) if_d ();
   regfile_if #(.DATA_W(32), .ADDR_W(5)) if_n ();
   regfile_if #(.DATA_W(32), .ADDR_W(5)) if_s ();

   assign if_d.we = we;  assign if_d.waddr = waddr;  assign if_d.wdata = wdata;
   assign if_d.wbe = wbe;  assign if_d.raddr_a = ra;  assign if_d.raddr_b = rb;
   assign if_n.we = we;  assign if_n.waddr = waddr;  assign if_n.wdata = wdata;
   assign if_n.wbe = wbe;  assign if_n.raddr_a = ra;  assign if_n.raddr_b = rb;
   assign if_s.we = we;  assign if_s.waddr = waddr;  assign if_s.wdata = wdata;
   assign if_s.wbe = wbe;  assign if_s.raddr_a = ra;  assign if_s.raddr_b = rb;

   regfile_2r1w #(.ZERO_REG(1), .BYPASS(1), .SYNC_READ(0)) u_dut_d (
      .i_clk(clk), .i_rst_n(rst_n), .bus(if_d));
   regfile_2r1w #(.ZERO_REG(0), .BYPASS(0), .SYNC_READ(0)) u_dut_n (
      .i_clk(clk), .i_rst_n(rst_n), .bus(if_n));
   regfile_2r1w #(.ZERO_REG(1), .BYPASS(1), .SYNC_READ(1)) u_dut_s (
      .i_clk(clk), .i_rst_n(rst_n), .bus(if_s));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for init_done; returns edges counted since call.
   task automatic wait_init(output int n);
      n = 0;
      while (n < 40 && !if_d.init_done) begin
         tick();
         n++;
      end
   endtask

   task automatic sweep_zero(input string tag);
      we = 1'b0;
      for (int a = 0; a < 32; a++) begin
         ra = 5'(a);
         rb = 5'(31 - a);
         #1;
         chk({tag, "_d_a"}, if_d.rdata_a, 32'h0);
         chk({tag, "_d_b"}, if_d.rdata_b, 32'h0);
         chk({tag, "_n_a"}, if_n.rdata_a, 32'h0);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      we = 1'b1; waddr = a; wdata = d; wbe = be;
   endtask

   initial begin
      rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wbe = '0; ra = 5'd3; rb = 5'd4;
      tick(); tick();
      chk("rst_done_d", 32'(if_d.init_done), 32'h0);
      chk("rst_done_s", 32'(if_s.init_done), 32'h0);
      chk("rst_rd_d_a", if_d.rdata_a, 32'h0);
      chk("rst_rd_s_a", if_s.rdata_a, 32'h0);
      chk("rst_rd_s_b", if_s.rdata_b, 32'h0);

      // Clear sequence with a write attempt that must be dropped.
      rst_n = 1'b1;
      wr(5'd9, 32'hFFFF_FFFF, 4'hF);
      ra = 5'd9;
      wait_init(n_edges);
      chk("init_lat", 32'(n_edges), 32'd32);
      chk("init_done_n", 32'(if_n.init_done), 32'h1);
      chk("init_done_s", 32'(if_s.init_done), 32'h1);
      sweep_zero("clr1");

      // Full then partial byte write to 5.
      wr(5'd5, 32'hDEAD_BEEF, 4'hF); ra = 5'd5; rb = 5'd6;
      #1;
      chk("byp_full_d", if_d.rdata_a, 32'hDEAD_BEEF);
      chk("nobyp_full_n", if_n.rdata_a, 32'h0);
      tick();
      chk("sync_byp_full", if_s.rdata_a, 32'hDEAD_BEEF);
      wr(5'd5, 32'h0000_1234, 4'h3);
      #1;
      chk("byp_part_d", if_d.rdata_a, 32'hDEAD_1234);
      chk("nobyp_part_n", if_n.rdata_a, 32'hDEAD_BEEF);
      tick();
      chk("sync_byp_part", if_s.rdata_a, 32'hDEAD_1234);
      wr(5'd5, 32'hFFFF_FFFF, 4'h0);
      tick();
      we = 1'b0;
      #1;
      chk("be0_d", if_d.rdata_a, 32'hDEAD_1234);
      chk("be0_n", if_n.rdata_a, 32'hDEAD_1234);
      chk("be0_s", if_s.rdata_a, 32'hDEAD_1234);

      // Entry 0 behaviour.
      wr(5'd0, 32'hFFFF_FFFF, 4'hF); ra = 5'd0;
      #1;
      chk("zero_byp_d", if_d.rdata_a, 32'h0);
      chk("zero_old_n", if_n.rdata_a, 32'h0);
      tick();
      we = 1'b0;
      #1;
      chk("zero_d", if_d.rdata_a, 32'h0);
      chk("nozero_n", if_n.rdata_a, 32'hFFFF_FFFF);

      // Both ports on the written address.
      wr(5'd7, 32'h1234_5678, 4'hF);
      tick();
      wr(5'd7, 32'hA5A5_A5A5, 4'hF); ra = 5'd7; rb = 5'd7;
      #1;
      chk("dual_byp_d_a", if_d.rdata_a, 32'hA5A5_A5A5);
      chk("dual_byp_d_b", if_d.rdata_b, 32'hA5A5_A5A5);
      chk("dual_old_n_a", if_n.rdata_a, 32'h1234_5678);
      chk("dual_old_n_b", if_n.rdata_b, 32'h1234_5678);
      tick();
      we = 1'b0;
      #1;
      chk("dual_new_n_a", if_n.rdata_a, 32'hA5A5_A5A5);
      chk("dual_new_n_b", if_n.rdata_b, 32'hA5A5_A5A5);
      chk("dual_sync_a", if_s.rdata_a, 32'hA5A5_A5A5);
      chk("dual_sync_b", if_s.rdata_b, 32'hA5A5_A5A5);

      // Registered read latency.
      wr(5'd3, 32'h0000_0011, 4'hF); ra = 5'd0; rb = 5'd0;
      tick();
      we = 1'b0; ra = 5'd3; rb = 5'd5;
      #1;
      chk("sync_pre_a", if_s.rdata_a, 32'h0);
      chk("comb_now_d", if_d.rdata_a, 32'h0000_0011);
      tick();
      chk("sync_lat_a", if_s.rdata_a, 32'h0000_0011);
      chk("sync_lat_b", if_s.rdata_b, 32'hDEAD_1234);

      // Reset from READY, then again mid-clear at ptr=10.
      rst_n = 1'b0;
      tick();
      chk("rst2_done", 32'(if_d.init_done), 32'h0);
      chk("rst2_sync_a", if_s.rdata_a, 32'h0);
      chk("rst2_comb_a", if_d.rdata_a, 32'h0);
      rst_n = 1'b1;
      wr(5'd12, 32'hCAFE_F00D, 4'hF);
      repeat (10) tick();
      chk("mid_done", 32'(if_d.init_done), 32'h0);
      chk("mid_rd_n", if_n.rdata_b, 32'h0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      wait_init(n_edges);
      chk("reinit_lat", 32'(n_edges), 32'd32);
      sweep_zero("clr2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
